// File: rtl/common_pkg.sv
// Shared cache-bus types and helpers used by the cbus initiators and responders.
package common;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2,
    SIZE_8B = 2'd3
  } cbus_size_t;

  // Encoded as beat count minus one so the beat count is len + 1.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } cbus_len_t;

  typedef enum logic {
    BURST_FIXED = 1'b0,
    BURST_INCR  = 1'b1
  } cbus_burst_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    cbus_size_t  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    cbus_len_t   len;
    cbus_burst_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_WAIT = 2'd1,
    RSP_BEAT = 2'd2,
    RSP_GAP  = 2'd3
  } cbus_rsp_state_t;

  function automatic logic [4:0] mlen_beats(input cbus_len_t len);
    return {1'b0, len} + 5'd1;
  endfunction

endpackage

// File: rtl/RAM_SinglePort.sv
// Single-port RAM with per-byte write strobes; READ_LATENCY 0 gives an asynchronous read.
module RAM_SinglePort #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 64,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 0
) (
  input  logic                             clk,
  input  logic                             en,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] strobe,
  output logic [DATA_WIDTH-1:0]            rdata
);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (strobe[b]) begin
          mem[addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_async_read
      assign rdata = mem[addr];
    end else begin : g_sync_read
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
        rdata_q <= mem[addr];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/cbus_mem_responder.sv
// Backing memory on the responder side of the cache bus: serves read/write bursts with
// programmable first-beat latency and inter-beat gaps, and flags unstable requests.
module cbus_mem_responder
  import common::*;
#(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int LATENCY        = 2,
  parameter int BEAT_GAP       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       protocol_err
);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'(BEAT_GAP);

  cbus_rsp_state_t           state;
  logic [CNT_W-1:0]          cnt;
  logic [4:0]                beats_left;
  logic [MEM_ADDR_WIDTH-1:0] word_idx;
  logic [31:0]               lat_addr;
  logic                      lat_write;
  cbus_size_t                lat_size;
  cbus_len_t                 lat_len;
  cbus_burst_t               lat_burst;
  logic                      ready_q;
  logic                      last_q;
  logic [63:0]               rdata;
  logic                      req_changed;

  assign req_changed = !creq.valid
                    || (creq.addr     != lat_addr)
                    || (creq.is_write != lat_write)
                    || (creq.size     != lat_size)
                    || (creq.len      != lat_len)
                    || (creq.burst    != lat_burst);

  // ready/last are registered and raised on entry to BEAT, so they always mirror state == RSP_BEAT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RSP_IDLE;
      cnt          <= '0;
      beats_left   <= '0;
      word_idx     <= '0;
      lat_addr     <= '0;
      lat_write    <= 1'b0;
      lat_size     <= SIZE_8B;
      lat_len      <= MLEN1;
      lat_burst    <= BURST_FIXED;
      ready_q      <= 1'b0;
      last_q       <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (state != RSP_IDLE && req_changed) begin
        protocol_err <= 1'b1;
      end
      case (state)
        RSP_IDLE: begin
          ready_q <= 1'b0;
          last_q  <= 1'b0;
          if (creq.valid) begin
            lat_addr   <= creq.addr;
            lat_write  <= creq.is_write;
            lat_size   <= creq.size;
            lat_len    <= creq.len;
            lat_burst  <= creq.burst;
            word_idx   <= creq.addr[MEM_ADDR_WIDTH+2:3];
            beats_left <= mlen_beats(creq.len);
            cnt        <= LAT_INIT;
            if (LATENCY == 0) begin
              state   <= RSP_BEAT;
              ready_q <= 1'b1;
              last_q  <= (mlen_beats(creq.len) == 5'd1);
            end else begin
              state <= RSP_WAIT;
            end
          end
        end
        RSP_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state   <= RSP_BEAT;
            ready_q <= 1'b1;
            last_q  <= (beats_left == 5'd1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RSP_BEAT: begin
          if (beats_left == 5'd1) begin
            state   <= RSP_IDLE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            beats_left <= beats_left - 5'd1;
            if (lat_burst == BURST_INCR) begin
              word_idx <= word_idx + MEM_ADDR_WIDTH'(1);
            end
            if (BEAT_GAP == 0) begin
              ready_q <= 1'b1;
              last_q  <= (beats_left == 5'd2);
            end else begin
              state   <= RSP_GAP;
              cnt     <= GAP_INIT;
              ready_q <= 1'b0;
              last_q  <= 1'b0;
            end
          end
        end
        RSP_GAP: begin
          if (cnt == CNT_W'(1)) begin
            state   <= RSP_BEAT;
            ready_q <= 1'b1;
            last_q  <= (beats_left == 5'd1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= RSP_IDLE;
      endcase
    end
  end

  // The write still lands if reset arrives during a write beat; memory is never cleared.
  RAM_SinglePort #(
    .ADDR_WIDTH  (MEM_ADDR_WIDTH),
    .DATA_WIDTH  (64),
    .BYTE_WIDTH  (8),
    .READ_LATENCY(0)
  ) u_ram (
    .clk   (clk),
    .en    (ready_q && lat_write),
    .addr  (word_idx),
    .wdata (creq.data),
    .strobe(creq.strobe),
    .rdata (rdata)
  );

  assign cresp = '{ready: ready_q,
                   last:  last_q,
                   data:  (ready_q && !lat_write) ? rdata : 64'd0};

endmodule
